// File: rtl/secure_reg_bank_if.sv
// Bus bundle for secure_reg_bank: password/data entry strobes in, bank contents
// and status out. The design side uses the slave modport.
interface secure_reg_bank_if #(
   parameter int DATA_W    = 4,
   parameter int NUM_REGS  = 4,
   parameter int MAX_TRIES = 3
);
   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int FC_W  = $clog2(MAX_TRIES + 1);

   logic [DATA_W-1:0]          pass_data;
   logic                       confirm;
   logic                       enable;
   logic [NUM_REGS*DATA_W-1:0] reg_bank;
   logic                       wr_valid;
   logic [IDX_W-1:0]           wr_index;
   logic [FC_W-1:0]            fail_count;
   logic                       locked;
   logic [2:0]                 current_state;

   modport master (
      output pass_data, confirm, enable,
      input  reg_bank, wr_valid, wr_index, fail_count, locked, current_state
   );

   modport slave (
      input  pass_data, confirm, enable,
      output reg_bank, wr_valid, wr_index, fail_count, locked, current_state
   );
endinterface

// File: rtl/secure_reg_bank.sv
// Password-gated register bank: a confirmed correct password opens a one-shot
// write window; the next confirmed word lands in reg[word mod NUM_REGS].
module secure_reg_bank #(
   parameter int                DATA_W       = 4,
   parameter int                NUM_REGS     = 4,
   parameter logic [DATA_W-1:0] PASSWORD     = 4'b1101,
   parameter int                MAX_TRIES    = 3,
   parameter int                LOCK_CYCLES  = 16,
   parameter int                AUTH_TIMEOUT = 32
) (
   input  logic             clk,
   input  logic             reset,
   secure_reg_bank_if.slave bus
);
   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int FC_W  = $clog2(MAX_TRIES + 1);
   localparam int AT_W  = $clog2(AUTH_TIMEOUT + 1);
   localparam int LC_W  = (LOCK_CYCLES > 0) ? $clog2(LOCK_CYCLES + 1) : 1;

   localparam logic [FC_W-1:0] FC_MAX     = FC_W'(MAX_TRIES);
   localparam logic [AT_W-1:0] AT_LIMIT   = AT_W'(AUTH_TIMEOUT);
   localparam logic [LC_W-1:0] LC_LIMIT   = LC_W'(LOCK_CYCLES);
   localparam bit              LOCK_TIMED = (LOCK_CYCLES != 0);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'b000,
      ST_AUTH  = 3'b001,
      ST_STORE = 3'b010,
      ST_FAIL  = 3'b011,
      ST_LOCK  = 3'b111
   } state_e;

   state_e                     state_q,    state_d;
   logic                       confirm_q;
   logic [DATA_W-1:0]          latch_q,    latch_d;
   logic [AT_W-1:0]            auth_tmr_q, auth_tmr_d;
   logic [LC_W-1:0]            lock_cnt_q, lock_cnt_d;
   logic [FC_W-1:0]            fail_q,     fail_d;
   logic [NUM_REGS*DATA_W-1:0] bank_q,     bank_d;
   logic                       wr_valid_q, wr_valid_d;
   logic [IDX_W-1:0]           wr_index_q, wr_index_d;
   logic                       locked_q,   locked_d;

   logic              ev_s;
   logic [IDX_W-1:0]  wr_idx_s;
   logic [AT_W-1:0]   auth_inc_s;
   logic [LC_W-1:0]   lock_inc_s;
   logic [FC_W-1:0]   fail_inc_s;
   logic              lock_done_s;

   assign ev_s        = bus.confirm & ~confirm_q;
   assign wr_idx_s    = latch_q[IDX_W-1:0];
   assign auth_inc_s  = auth_tmr_q + AT_W'(1);
   assign lock_inc_s  = lock_cnt_q + LC_W'(1);
   assign fail_inc_s  = (fail_q == FC_MAX) ? fail_q : (fail_q + FC_W'(1));
   assign lock_done_s = LOCK_TIMED && (lock_inc_s == LC_LIMIT);

   // Next-state, bank update and registered-output precomputation.
   always_comb begin
      state_d    = state_q;
      latch_d    = latch_q;
      auth_tmr_d = auth_tmr_q;
      lock_cnt_d = lock_cnt_q;
      fail_d     = fail_q;
      bank_d     = bank_q;
      wr_index_d = wr_index_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.enable && ev_s) begin
               if (bus.pass_data == PASSWORD) begin
                  state_d    = ST_AUTH;
                  fail_d     = '0;
                  auth_tmr_d = '0;
               end else begin
                  state_d = ST_FAIL;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_AUTH: begin
            // A confirm edge on the expiry cycle still wins over the timeout.
            if (!bus.enable) begin
               state_d = ST_IDLE;
            end else if (ev_s) begin
               latch_d = bus.pass_data;
               state_d = ST_STORE;
            end else if (auth_inc_s == AT_LIMIT) begin
               state_d = ST_IDLE;
            end else begin
               auth_tmr_d = auth_inc_s;
            end
         end
         ST_STORE: begin
            for (int i = 0; i < NUM_REGS; i++) begin
               if (wr_idx_s == IDX_W'(i)) begin
                  bank_d[i*DATA_W +: DATA_W] = latch_q;
               end else begin
                  bank_d[i*DATA_W +: DATA_W] = bank_q[i*DATA_W +: DATA_W];
               end
            end
            wr_index_d = wr_idx_s;
            state_d    = ST_IDLE;
         end
         ST_FAIL: begin
            fail_d     = fail_inc_s;
            lock_cnt_d = '0;
            state_d    = (fail_inc_s == FC_MAX) ? ST_LOCK : ST_IDLE;
         end
         ST_LOCK: begin
            if (lock_done_s) begin
               state_d = ST_IDLE;
               fail_d  = '0;
            end else begin
               lock_cnt_d = lock_inc_s;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      wr_valid_d = (state_d == ST_STORE);
      locked_d   = (state_d == ST_LOCK);
   end

   // State and output registers, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         confirm_q  <= 1'b0;
         latch_q    <= '0;
         auth_tmr_q <= '0;
         lock_cnt_q <= '0;
         fail_q     <= '0;
         bank_q     <= '0;
         wr_valid_q <= 1'b0;
         wr_index_q <= '0;
         locked_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         confirm_q  <= bus.confirm;
         latch_q    <= latch_d;
         auth_tmr_q <= auth_tmr_d;
         lock_cnt_q <= lock_cnt_d;
         fail_q     <= fail_d;
         bank_q     <= bank_d;
         wr_valid_q <= wr_valid_d;
         wr_index_q <= wr_index_d;
         locked_q   <= locked_d;
      end
   end

   assign bus.reg_bank      = bank_q;
   assign bus.wr_valid      = wr_valid_q;
   assign bus.wr_index      = wr_index_q;
   assign bus.fail_count    = fail_q;
   assign bus.locked        = locked_q;
   assign bus.current_state = state_q;
endmodule
